// File: rtl/serial_pkg.sv
// Shared types for the serial transmitter.
//   parity_mode_e : parity selection for a frame (none / odd / even)
//   tx_state_e    : transmitter FSM states, also exported on the debug port
//   parity_bit()  : parity bit value from the XOR of the data bits
package serial_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // data_xor is 1 when the data word holds an odd number of ones.
  // Odd mode tops the total up to odd, even mode tops it up to even.
  function automatic logic parity_bit(input parity_mode_e mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/sync_fifo_sc.sv
// Single-clock FIFO holding words waiting to be serialised.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; ignored while full
//   pop        : read request; ignored while empty; dout advances on the edge
//   dout       : oldest stored word (valid while empty=0)
//   full,empty : registered occupancy flags
// A push and a pop on the same edge leave the count unchanged. A pop never
// makes room for a push on the same edge because full is sampled before it.
module sync_fifo_sc #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset: only entries written since reset are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/serial_send_fifo_circuit.sv
// UART-style serial transmitter with an input FIFO.
// Frame: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Every bit lasts WAIT_COUNT_BASE clocks and queued
// words go out back-to-back without an idle bit between frames.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : word to queue
//   we         : write strobe
//   full       : FIFO holds FIFO_DEPTH words
//   ovf        : one-cycle pulse after a write was dropped because full was set
//   data_out   : serial line, idles high
//   busy       : frame in progress or words waiting
//   tx_state   : current FSM state, for observation only
// Handshake: a word is taken on a rising edge where we=1 and full=0; with
// we=1 and full=1 it is dropped and ovf pulses on the following cycle. There
// is no backpressure beyond full; the writer must watch it.
module serial_send_fifo_circuit
  import serial_pkg::*;
#(
  parameter int           WAIT_COUNT_BASE = 10,
  parameter int           DATA_WIDTH      = 8,
  parameter parity_mode_e PARITY_MODE     = PAR_NONE,
  parameter int           STOP_BITS       = 1,
  parameter int           FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  output logic                  full,
  output logic                  ovf,
  output logic                  data_out,
  output logic                  busy,
  output tx_state_e             tx_state
);

  localparam int CW = $clog2(WAIT_COUNT_BASE);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(WAIT_COUNT_BASE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH);

  tx_state_e             state;
  logic [CW-1:0]         baud_cnt;
  logic [IW-1:0]         bit_idx;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_acc;

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  baud_tick;
  logic                  last_stop;
  logic                  push_ok;

  assign baud_tick = (baud_cnt == BAUD_LAST);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign push_ok   = we && !fifo_full;

  // The FIFO is popped on the very edge the FSM loads the shift register:
  // either from IDLE, or on the edge that closes the last stop bit.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) || (state == STOP && baud_tick && last_stop));

  assign full     = fifo_full;
  assign tx_state = state;

  sync_fifo_sc #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (we),
    .pop   (fifo_pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      data_out <= 1'b1;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      ovf <= we && fifo_full;

      // The baud counter rests at zero in IDLE so the start bit gets a full
      // bit time; elsewhere it free-runs and wraps every bit.
      if (state == IDLE) begin
        baud_cnt <= '0;
      end else if (baud_tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg    <= fifo_dout;
            bit_idx  <= '0;
            par_acc  <= 1'b0;
            data_out <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end else begin
            // A write landing now raises busy one edge later, together
            // with the start bit.
            busy <= 1'b0;
          end
        end

        START: begin
          if (baud_tick) begin
            data_out <= shreg[0];
            par_acc  <= shreg[0];
            shreg    <= {1'b0, shreg[DATA_WIDTH-1:1]};
            bit_idx  <= IW'(1);
            state    <= DATA;
          end
        end

        DATA: begin
          // bit_idx counts data bits already placed on the line.
          if (baud_tick) begin
            if (bit_idx == IDX_LAST) begin
              if (PARITY_MODE != PAR_NONE) begin
                data_out <= parity_bit(PARITY_MODE, par_acc);
                state    <= PARITY;
              end else begin
                data_out <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              data_out <= shreg[0];
              par_acc  <= par_acc ^ shreg[0];
              shreg    <= {1'b0, shreg[DATA_WIDTH-1:1]};
              bit_idx  <= bit_idx + 1'b1;
            end
          end
        end

        PARITY: begin
          if (baud_tick) begin
            data_out <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end

        STOP: begin
          if (baud_tick) begin
            if (last_stop) begin
              if (!fifo_empty) begin
                // Next frame starts on this same edge: no idle gap.
                shreg    <= fifo_dout;
                bit_idx  <= '0;
                par_acc  <= 1'b0;
                data_out <= 1'b0;
                state    <= START;
              end else begin
                state <= IDLE;
                // A word written on this closing edge keeps busy up
                // until its own frame starts on the next edge.
                busy  <= push_ok;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          data_out <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
